ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: RAM data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: RAM address width in bits (32 words).
REQ-003 SHALL have parameter RD_LAT, default 1: RAM read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have parameter LOCK_MAX, default 8: maximum number of consecutive locked grants.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 2 bits: per-requester request valid; bit i belongs to requester i.
REQ-008 SHALL have port req_ready, output, 2 bits: per-requester request accepted this cycle.
REQ-009 SHALL have port req_we, input, 2 bits: per-requester write enable (1 = write, 0 = read).
REQ-010 SHALL have port req_addr, input, 2*ADDR_W bits: per-requester address; requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port req_wdata, input, 2*DATA_W bits: per-requester write data; requester i occupies slice [i*DATA_W +: DATA_W].
REQ-012 SHALL have port req_lock, input, 2 bits: per-requester request to hold the grant after the current transfer.
REQ-013 SHALL have port rsp_valid, output, 2 bits: per-requester read data valid.
REQ-014 SHALL have port rsp_rdata, output, DATA_W bits: read data, shared by both requesters and qualified by rsp_valid.
REQ-015 SHALL have ports ram_en, output, 1 bit, and ram_we, output, 1 bit: RAM enable and RAM write enable.
REQ-016 SHALL have ports ram_addr, output, ADDR_W bits, and ram_wdata, output, DATA_W bits: RAM address and RAM write data.
REQ-017 SHALL have port ram_rdata, input, DATA_W bits: RAM read data.

Function
REQ-018 SHALL accept at most one request per cycle; a request transfers on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-019 SHALL drive req_ready combinationally from the current grant; req_ready SHALL be one-hot or zero, and SHALL be zero when req_valid is zero.
REQ-020 SHALL drive ram_en, ram_we, ram_addr and ram_wdata combinationally from the accepted requester in the same cycle (zero added latency).
REQ-021 SHALL hold ram_en = 0 and ram_we = 0 when no request is accepted.
REQ-022 SHALL arbitrate round-robin: on a conflict, the requester not granted most recently wins; a lone valid requester always wins.
REQ-023 SHALL update the last-grant pointer only on an accepted transfer.
REQ-024 SHALL assert rsp_valid[i] for exactly one cycle, RD_LAT cycles after acceptance of a read from requester i.
REQ-025 SHALL present rsp_rdata = ram_rdata in the same cycle as that rsp_valid pulse.
REQ-026 SHALL track outstanding reads with an RD_LAT-deep shift register of {valid, id}.
REQ-027 SHALL pipeline back-to-back reads (including alternating requesters) with no bubbles.
REQ-028 SHALL generate no rsp_valid for a write.
REQ-029 SHALL use a two-state grant FSM: ARB (arbitrate each cycle) and LOCKED (grant held by the lock owner).
REQ-030 SHALL leave ARB for LOCKED on an accepted transfer with req_lock[owner] = 1.
REQ-031 SHALL return from LOCKED to ARB when any of the following holds: req_lock[owner] = 0 on an accepted transfer; the owner drops req_valid; or the lock counter reaches LOCK_MAX accepted transfers.
REQ-032 SHALL, while in LOCKED, keep req_ready low for the non-owner even when it is valid.
REQ-033 SHALL, on a lock-counter release, make the other requester win the next conflict.
REQ-034 SHALL saturate the lock counter at LOCK_MAX and clear it on entry to ARB.

Reset
REQ-035 SHALL, on sys_rst, asynchronously force: FSM = ARB, last-grant pointer = 1 (requester 0 wins the first conflict), lock counter = 0, read tracking = empty.
REQ-036 SHALL force req_ready, rsp_valid and ram_en/ram_we to 0 while sys_rst is high; rsp_rdata during reset is don't-care.
REQ-037 SHALL discard in-flight reads on reset without any rsp_valid, including reset asserted mid-lock or mid-read.

Configuration
REQ-038 SHALL compile the lock feature only when macro RAM_ARB_LOCK_EN is defined: LOCKED state, lock counter and req_lock usage are present.
REQ-039 SHALL, when RAM_ARB_LOCK_EN is undefined, ignore req_lock (port retained), remove the LOCKED state and the lock counter, and arbitrate pure round-robin every cycle.

Structure
REQ-040 SHALL place in shared package ram_arb_pkg: the FSM state encoding (ARB, LOCKED) and the requester-id constants (REQ0 = 0, REQ1 = 1).
REQ-041 SHALL implement the grant decision (pointer, lock state, lock counter) in sub-module ram_rr_arb; response tracking and RAM muxing stay in ram_arbiter.

Verification
REQ-042 SHALL cover: req0 writes addr 3 = 0xA5, then req0 reads addr 3 -> rsp_valid[0] pulse RD_LAT cycles after acceptance, rsp_rdata = 0xA5, rsp_valid[1] stays 0.
REQ-043 SHALL cover: both requesters hold continuous reads for 6 cycles -> grants alternate 0,1,0,1,0,1 and responses return in the same order with no bubbles.
REQ-044 SHALL cover (RAM_ARB_LOCK_EN defined): req1 holds req_lock = 1 with req0 always valid -> req1 gets 8 consecutive grants, then req0 is granted.
REQ-045 SHALL cover (RAM_ARB_LOCK_EN undefined): the same stimulus as REQ-044 -> strict alternation.
REQ-046 SHALL cover: sys_rst asserted one cycle after a read acceptance -> no rsp_valid, and after release the first conflict goes to req0.
REQ-047 SHALL cover: RD_LAT = 2 with a write immediately following a read -> exactly one rsp_valid, 2 cycles after the read.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared definitions for the two-requester RAM arbiter:
//               grant FSM state encoding and requester-id constants.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  // Grant FSM: ARB arbitrates every cycle, LOCKED holds the grant for the owner
  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Requester identifiers, also used as bit indices into the 2-bit vectors
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ram_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ram_rr_arb
// Description : Two-way round-robin grant decision with optional grant lock.
//               Holds the last-grant pointer, the grant FSM and the lock
//               counter. The lock feature is built only when RAM_ARB_LOCK_EN
//               is defined; otherwise req lock inputs are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rr_arb
  import ram_arb_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  output logic [1:0] grant
);

  // Requester granted most recently; in LOCKED it is also the lock owner
  logic       last;
  logic [1:0] rr_grant;
  logic [1:0] raw_grant;

  // Round-robin pick: lone requester wins, a conflict goes to the one not last served
  always_comb begin
    rr_grant = valid;
    if (valid == 2'b11) begin
      rr_grant = (last == REQ1) ? 2'b01 : 2'b10;
    end
  end

`ifdef RAM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next-state, lock counter and grant selection
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    raw_grant = rr_grant;
    case (state)
      ARB: begin
        cnt_nxt = '0;
        // The entry transfer itself counts as the first locked grant
        if ((|rr_grant) && lock[rr_grant[1]] && (LOCK_MAX > 1)) begin
          state_nxt = LOCKED;
          cnt_nxt   = CNT_W'(1);
        end
      end
      LOCKED: begin
        // Only the owner may be served; the other side stays blocked
        raw_grant = valid[last] ? ((last == REQ1) ? 2'b10 : 2'b01) : 2'b00;
        if (!valid[last] || !lock[last] || ((int'(cnt) + 1) >= LOCK_MAX)) begin
          state_nxt = ARB;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ARB;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Grant FSM state and lock counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
`else
  // Lock inputs are kept on the interface but have no effect in this build
  logic unused_lock;
  assign unused_lock = ^lock;

  // Pure round-robin every cycle
  always_comb begin
    raw_grant = rr_grant;
  end
`endif

  // No grant may be issued while reset is asserted
  assign grant = raw_grant & {2{~rst}};

  // Last-grant pointer moves only on an accepted transfer; after reset REQ0 wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= REQ1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-requester arbiter in front of a single-port RAM. The
//               accepted request drives the RAM combinationally; read
//               responses are routed back after RD_LAT cycles (1 or 2).
//               Grant locking is built when RAM_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [1:0]          req_lock,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  logic [1:0]        grant;
  logic              sel;
  logic              rd_new;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_id;

  ram_rr_arb #(
    .LOCK_MAX (LOCK_MAX)
  ) u_arb (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .valid (req_valid),
    .lock  (req_lock),
    .grant (grant)
  );

  assign req_ready = grant;
  assign sel       = grant[REQ1];

  // Zero-latency RAM mux from the accepted requester
  assign ram_en    = |grant;
  assign ram_we    = ram_en & req_we[sel];
  assign ram_addr  = sel ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
  assign ram_wdata = sel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];

  assign rd_new = ram_en & ~ram_we;

  // Outstanding-read tracker: one {valid, id} entry per cycle of RAM latency
  generate
    if (RD_LAT == 1) begin : g_lat1
      // Single-stage tracker
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          pipe_v  <= '0;
          pipe_id <= '0;
        end else begin
          pipe_v  <= rd_new;
          pipe_id <= sel;
        end
      end
    end else begin : g_latn
      // Multi-stage tracker, shifts every cycle so reads pipeline without bubbles
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          pipe_v  <= '0;
          pipe_id <= '0;
        end else begin
          pipe_v  <= {pipe_v[RD_LAT-2:0], rd_new};
          pipe_id <= {pipe_id[RD_LAT-2:0], sel};
        end
      end
    end
  endgenerate

  assign rsp_valid[REQ0] = pipe_v[RD_LAT-1] & (pipe_id[RD_LAT-1] == REQ0);
  assign rsp_valid[REQ1] = pipe_v[RD_LAT-1] & (pipe_id[RD_LAT-1] == REQ1);
  assign rsp_rdata       = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed self-checking bench for ram_arbiter. Instance u_dut
//               uses RD_LAT=1, instance u_dut2 uses RD_LAT=2; each has its
//               own small RAM model. Lock expectations follow RAM_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic            sys_clk = 1'b0;
  logic            sys_rst;

  // Instance 1 (RD_LAT = 1)
  logic [1:0]      req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ram_wdata, ram_rdata;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;

  // Instance 2 (RD_LAT = 2)
  logic [1:0]      b_req_valid, b_req_ready, b_req_we, b_req_lock, b_rsp_valid;
  logic [2*AW-1:0] b_req_addr;
  logic [2*DW-1:0] b_req_wdata;
  logic [DW-1:0]   b_rsp_rdata, b_ram_wdata, b_ram_rdata;
  logic            b_ram_en, b_ram_we;
  logic [AW-1:0]   b_ram_addr;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .LOCK_MAX(8)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .LOCK_MAX(8)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_lock(b_req_lock),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // RAM models: write-through port, registered read (1 and 2 cycles)
  logic [DW-1:0] mem_a [0:31];
  logic [DW-1:0] mem_b [0:31];
  logic [DW-1:0] rd_b1;

  always @(posedge sys_clk) begin
    if (ram_en && ram_we) mem_a[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem_a[ram_addr];
  end

  always @(posedge sys_clk) begin
    if (b_ram_en && b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
    if (b_ram_en && !b_ram_we) rd_b1 <= mem_b[b_ram_addr];
    b_ram_rdata <= rd_b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rst_pulse();
    sys_rst   = 1'b1;
    req_valid = 2'b00;
    tick();
    sys_rst   = 1'b0;
  endtask

  // Expected grant for cycle c of the lock scenario
  function automatic logic [1:0] exp_lock(input int c);
`ifdef RAM_ARB_LOCK_EN
    if (c == 0 || c == 9 || c == 12) return 2'b01;
    if (c == 11) return 2'b00;
    return 2'b10;
`else
    if (c == 11) return 2'b01;
    if (c == 12) return 2'b10;
    return (c % 2 == 0) ? 2'b01 : 2'b10;
`endif
  endfunction

  initial begin
    logic [1:0] exp_g;
    logic [1:0] prev_g;

    sys_rst     = 1'b1;
    req_valid   = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    b_req_valid = '0; b_req_we = '0; b_req_lock = '0; b_req_addr = '0; b_req_wdata = '0;
    prev_g      = '0;

    // Reset: outputs forced low even with requests pending
    tick();
    req_valid   = 2'b11;
    b_req_valid = 2'b11;
    @(negedge sys_clk);
    check("rst_ready", req_ready, 2'b00);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_rsp", rsp_valid, 2'b00);
    check("rst_b_ready", b_req_ready, 2'b00);
    tick();
    sys_rst     = 1'b0;
    req_valid   = 2'b00;
    b_req_valid = 2'b00;

    // Write then read back through requester 0
    req_valid = 2'b01; req_we = 2'b01; req_addr = 10'd3; req_wdata = 16'h00A5;
    @(negedge sys_clk);
    check("wr_ready", req_ready, 2'b01);
    check("wr_ram_en", ram_en, 1'b1);
    check("wr_ram_we", ram_we, 1'b1);
    check("wr_ram_addr", ram_addr, 5'd3);
    check("wr_ram_wdata", ram_wdata, 8'hA5);
    tick();
    req_we = 2'b00;
    @(negedge sys_clk);
    check("rd_ready", req_ready, 2'b01);
    check("rd_ram_we", ram_we, 1'b0);
    check("wr_no_rsp", rsp_valid, 2'b00);
    tick();
    req_valid = 2'b00;
    @(negedge sys_clk);
    check("rd_rsp", rsp_valid, 2'b01);
    check("rd_rdata", rsp_rdata, 8'hA5);
    check("idle_ram_en", ram_en, 1'b0);
    tick();
    @(negedge sys_clk);
    check("rd_rsp_single", rsp_valid, 2'b00);
    tick();

    // Preload addr 1 and 2, then continuous reads from both requesters
    req_valid = 2'b01; req_we = 2'b01; req_addr = {5'd0, 5'd1}; req_wdata = {8'h00, 8'h11};
    tick();
    req_valid = 2'b10; req_we = 2'b10; req_addr = {5'd2, 5'd0}; req_wdata = {8'h22, 8'h00};
    tick();
    rst_pulse();
    req_valid = 2'b11; req_we = 2'b00; req_addr = {5'd2, 5'd1};
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) req_valid = 2'b00;
      @(negedge sys_clk);
      if (k < 6) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        check($sformatf("alt_grant%0d", k), req_ready, exp_g);
      end
      if (k > 0) begin
        check($sformatf("alt_rsp%0d", k), rsp_valid, prev_g);
        check($sformatf("alt_rdata%0d", k), rsp_rdata, (prev_g == 2'b01) ? 8'h11 : 8'h22);
      end
      prev_g = exp_g;
      tick();
    end
    @(negedge sys_clk);
    check("alt_rsp_end", rsp_valid, 2'b00);
    tick();

    // Lock scenario: requester 1 asks for lock, requester 0 always valid
    rst_pulse();
    req_valid = 2'b11; req_we = 2'b11; req_lock = 2'b10; req_addr = {5'd9, 5'd8};
    for (int c = 0; c <= 12; c++) begin
      if (c == 11) req_valid = 2'b01;
      if (c == 12) req_valid = 2'b11;
      @(negedge sys_clk);
      check($sformatf("lock_grant%0d", c), req_ready, exp_lock(c));
      tick();
    end
    req_valid = 2'b00; req_lock = 2'b00; req_we = 2'b00;
    tick();

    // Reset one cycle after a read acceptance
    rst_pulse();
    req_valid = 2'b01; req_we = 2'b00; req_addr = 10'd3;
    @(negedge sys_clk);
    check("mid_rd_ready", req_ready, 2'b01);
    tick();
    sys_rst = 1'b1; req_valid = 2'b00;
    @(negedge sys_clk);
    check("mid_rd_rsp_rst", rsp_valid, 2'b00);
    tick();
    @(negedge sys_clk);
    check("mid_rd_rsp_rst2", rsp_valid, 2'b00);
    tick();
    sys_rst = 1'b0; req_valid = 2'b11;
    @(negedge sys_clk);
    check("post_rst_grant", req_ready, 2'b01);
    check("post_rst_rsp", rsp_valid, 2'b00);
    tick();
    req_valid = 2'b00;
    tick();

    // RD_LAT = 2: read followed immediately by a write
    b_req_valid = 2'b01; b_req_we = 2'b01; b_req_addr = 10'd4; b_req_wdata = 16'h003C;
    tick();
    b_req_we = 2'b00;
    @(negedge sys_clk);
    check("l2_rd_ready", b_req_ready, 2'b01);
    check("l2_rsp_c0", b_rsp_valid, 2'b00);
    tick();
    b_req_we = 2'b01; b_req_addr = 10'd5; b_req_wdata = 16'h0077;
    @(negedge sys_clk);
    check("l2_rsp_c1", b_rsp_valid, 2'b00);
    tick();
    b_req_valid = 2'b00; b_req_we = 2'b00;
    @(negedge sys_clk);
    check("l2_rsp_c2", b_rsp_valid, 2'b01);
    check("l2_rdata", b_rsp_rdata, 8'h3C);
    tick();
    @(negedge sys_clk);
    check("l2_rsp_c3", b_rsp_valid, 2'b00);
    tick();
    @(negedge sys_clk);
    check("l2_rsp_c4", b_rsp_valid, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
